segment_scan_reader: RTL and testbench
======================================

Name: segment_scan_reader

Overview:
Monitors a multiplexed, active-low 7-segment display bus (shared segment lines plus per-digit anode enables) and recovers the hex value shown on each digit. A digit is captured once its pins have been stable long enough, and the segment pattern is mapped back to a nibble. A complete frame is presented on a valid/ready output. Used for display loopback checking and for scraping values from external scanned displays.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
STABLE_CYCLES, 4, consecutive identical samples required before capture (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
seg_n  in  7  segment lines {a,b,c,d,e,f,g}, bit6=a, 0=lit
an_n  in  NUM_DIGITS  digit enables, 0=digit k driven
value_o  out  4*NUM_DIGITS  digit k nibble at [4k+3:4k]
invalid_o  out  NUM_DIGITS  bit k set: digit k pattern not in table
valid_o  out  1  frame available
ready_i  in  1  consumer accepts frame
overrun_o  out  1  sticky: completed frame dropped

Behaviour:
- Decoding table, seg_n to nibble: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9, 0001000=A, 1100000=B, 0110001=C, 1000010=D, 0110000=E, 0111000=F. Any other pattern decodes to 0 and sets the invalid flag.
- Sample register s holds {an_n, seg_n}; counter cnt saturates at STABLE_CYCLES.
- On each edge: if pins != s, then s<=pins and cnt<=1. Otherwise cnt<=min(cnt+1, STABLE_CYCLES).
- Capture strobe: cnt==STABLE_CYCLES-1 and pins==s. The capture therefore occurs on the STABLE_CYCLES-th consecutive edge with identical pins, exactly once per stable interval.
- At capture, if an_n has exactly one low bit k: slot k <= decoded nibble, inv k <= invalid flag, captured[k] <= 1. A re-capture of digit k overwrites the slot (latest value wins).
- At capture with an_n all high or more than one bit low: no state change.
- FSM states:
  - COLLECT: collect until captured is all ones, then go to DELIVER. The evaluation happens the cycle after the last capture.
  - DELIVER, single cycle: if !valid_o or ready_i, load value_o/invalid_o from the slots, set valid_o=1 next cycle, clear captured, return to COLLECT. Otherwise set overrun_o=1, clear captured, leave the output untouched, return to COLLECT.
- Captures continue during DELIVER. A capture landing in that cycle applies after captured is cleared, so it counts toward the next frame.
- Handshake: valid_o stays high until a cycle with ready_i=1, then drops the next cycle unless a new frame loads in that same cycle. value_o/invalid_o are stable while valid_o && !ready_i.
- Latency: valid_o rises 2 cycles after the final digit capture edge.
- Reset (async, any time including mid-frame):
  - s = all ones, cnt = 0, captured = 0, slots = 0
  - value_o = 0, invalid_o = 0, valid_o = 0, overrun_o = 0
  - FSM = COLLECT
  - A partially collected frame is discarded.
- overrun_o is cleared only by reset.

Optional Feature:
- SEG_SYNC_EN defined: seg_n and an_n pass through a 2-flop synchroniser before the sample logic. All capture and valid timing shifts 2 cycles later. Reset value of both synchroniser stages is all ones.
- SEG_SYNC_EN undefined: pins feed the sample logic directly, with timing as stated above.

Test Plan (NUM_DIGITS=4, STABLE_CYCLES=4, SEG_SYNC_EN off):
- Scan sequence:
  - Stimulus: digit0..3 show 1,2,3,4 (an_n=1110/1101/1011/0111, seg_n per table), 8 cycles each; ready_i=1.
  - Response: valid_o high for 1 cycle, 2 cycles after the digit3 capture; value_o=16'h4321; invalid_o=0000.
- Glitch rejection:
  - Stimulus: during digit2 dwell, insert 3-cycle seg_n=0000000, then return to pattern 3.
  - Response: no capture of 8; frame value 16'h4321.
- Invalid pattern:
  - Stimulus: digit1 shows seg_n=1111111 for 8 cycles.
  - Response: frame value_o=16'h4301; invalid_o=0010.
- Backpressure:
  - Stimulus: ready_i=0; two complete frames (0x4321 then 0xBEEF: digit0=F, digit1=E, digit2=E, digit3=B).
  - Response: value_o holds 16'h4321 with valid_o=1 throughout; overrun_o=1 after the second frame completes; raising ready_i drops valid_o the next cycle.
- Ambiguous anodes:
  - Stimulus: an_n=1100 stable for 10 cycles.
  - Response: captured unchanged; no frame.
- Reset mid-frame:
  - Stimulus: digits 0,1 captured, then assert rst asynchronously for 2 cycles, then scan a full frame of 0xA5C0 (digit0=0, digit1=C, digit2=5, digit3=A).
  - Response: all outputs read 0 during reset; the next frame is value_o=16'hA5C0 with no residue from the earlier digits.

Source files
------------

// File: rtl/segment_scan_reader.sv
// segment_scan_reader: recovers hex digits from a scanned active-low 7-segment bus and delivers frames on valid/ready
// Ports: clk, rst (async, active-high); seg_n {a..g} active-low; an_n per-digit enable active-low;
//        value_o nibble per digit; invalid_o per-digit bad-pattern flag; valid_o/ready_i frame handshake;
//        overrun_o sticky dropped-frame flag.
// Build option: define SEG_SYNC_EN to pass seg_n/an_n through a 2-flop synchroniser (adds 2 cycles of latency).
module segment_scan_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] value_o,
  output logic [NUM_DIGITS-1:0]   invalid_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    overrun_o
);
  localparam int W  = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DELIVER = 1'b1;
  logic [W-1:0] pins;
`ifdef SEG_SYNC_EN
  logic [W-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {an_n, seg_n};
      sync2_q <= sync1_q;
    end
  assign pins = sync2_q;
`else
  assign pins = {an_n, seg_n};
`endif
  logic [W-1:0] s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0] captured_q, captured_d, slot_inv_q, slot_inv_d, invalid_q, invalid_d;
  logic [4*NUM_DIGITS-1:0] slot_q, slot_d, value_q, value_d;
  logic [0:0] state_q, state_d;
  logic valid_q, valid_d, overrun_q, overrun_d;
  logic [NUM_DIGITS-1:0] an_s;
  logic [3:0] nib;
  logic bad, same, cap, deliver, load;
  assign an_s = pins[W-1:7];
  always_comb begin
    nib = 4'h0;
    bad = 1'b0;
    case (pins[6:0])
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0000100: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b1100000: nib = 4'hB;
      7'b0110001: nib = 4'hC;
      7'b1000010: nib = 4'hD;
      7'b0110000: nib = 4'hE;
      7'b0111000: nib = 4'hF;
      default:    bad = 1'b1;
    endcase
  end
  // Strobe fires on the edge that saturates the stable counter, so once per stable interval.
  assign same    = pins == s_q;
  assign cap     = same && cnt_q == CW'(STABLE_CYCLES - 1) && $onehot(~an_s);
  assign deliver = state_q == DELIVER;
  assign load    = deliver && (!valid_q || ready_i);
  always_comb begin
    s_d        = pins;
    cnt_d      = !same ? CW'(1) : (cnt_q == CW'(STABLE_CYCLES) ? cnt_q : cnt_q + CW'(1));
    state_d    = (state_q == COLLECT && &captured_q) ? DELIVER : COLLECT;
    // Clear first so a capture in the delivery cycle counts toward the next frame.
    captured_d = deliver ? '0 : captured_q;
    slot_d     = slot_q;
    slot_inv_d = slot_inv_q;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (cap && !an_s[k]) begin
        captured_d[k]     = 1'b1;
        slot_d[4*k +: 4]  = nib;
        slot_inv_d[k]     = bad;
      end
    value_d   = load ? slot_q : value_q;
    invalid_d = load ? slot_inv_q : invalid_q;
    valid_d   = load | (valid_q & ~ready_i);
    overrun_d = overrun_q | (deliver & ~load);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s_q        <= '1;
      cnt_q      <= '0;
      captured_q <= '0;
      slot_q     <= '0;
      slot_inv_q <= '0;
      value_q    <= '0;
      invalid_q  <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      state_q    <= COLLECT;
    end else begin
      s_q        <= s_d;
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
      slot_q     <= slot_d;
      slot_inv_q <= slot_inv_d;
      value_q    <= value_d;
      invalid_q  <= invalid_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      state_q    <= state_d;
    end
  assign value_o   = value_q;
  assign invalid_o = invalid_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;
endmodule

// File: tb/tb_segment_scan_reader.sv
// tb_segment_scan_reader: directed and random checks of segment_scan_reader against a run-length reference model
module tb_segment_scan_reader;
  localparam int ND = 4;
  localparam int SC = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] seg_n = '1;
  logic [ND-1:0] an_n = '1;
  logic ready_i = 1'b1;
  logic [4*ND-1:0] value_o;
  logic [ND-1:0] invalid_o;
  logic valid_o, overrun_o;
  always #5 clk = ~clk;
  segment_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n), .value_o(value_o),
    .invalid_o(invalid_o), .valid_o(valid_o), .ready_i(ready_i), .overrun_o(overrun_o)
  );
  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  int n_chk = 0, n_fail = 0;
  logic [10:0] m_prev;
  int m_run, m_due;
  logic [3:0] m_mask, m_slot [4];
  logic m_sinv [4];
  logic [15:0] m_val;
  logic [3:0] m_inv;
  logic m_valid, m_ovr;
  int nvalid = 0;
  logic [15:0] last_val = '0;
  logic [3:0] last_inv = '0;
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_prev = '1; m_run = 0; m_due = 0; m_mask = '0;
    for (int i = 0; i < 4; i++) begin m_slot[i] = '0; m_sinv[i] = 1'b0; end
    m_val = '0; m_inv = '0; m_valid = 1'b0; m_ovr = 1'b0;
  endtask
  // One clock edge of the reference: a run of identical pins captures on its SC-th edge;
  // a completed set of digits is delivered two edges after the completing capture.
  task automatic model_edge(input logic [10:0] p, input logic r);
    int zeros, kk;
    logic [3:0] nb;
    logic bd, cp, dlv;
    if (p == m_prev) m_run++;
    else begin m_prev = p; m_run = 1; end
    cp = (m_run == SC);
    dlv = (m_due == 1);
    if (m_due > 0) m_due--;
    if (dlv) begin
      if (!m_valid || r) begin
        for (int i = 0; i < 4; i++) begin m_val[4*i +: 4] = m_slot[i]; m_inv[i] = m_sinv[i]; end
        m_valid = 1'b1;
      end else m_ovr = 1'b1;
      m_mask = '0;
    end else if (r) m_valid = 1'b0;
    zeros = 0; kk = 0;
    for (int i = 0; i < 4; i++) if (!p[7+i]) begin zeros++; kk = i; end
    if (cp && zeros == 1) begin
      nb = '0; bd = 1'b1;
      for (int i = 0; i < 16; i++) if (seg_tab[i] == p[6:0]) begin nb = 4'(i); bd = 1'b0; end
      m_slot[kk] = nb; m_sinv[kk] = bd; m_mask[kk] = 1'b1;
    end
    if (m_mask == 4'hF && m_due == 0) m_due = 2;
  endtask
  task automatic step(input logic [3:0] an, input logic [6:0] seg, input logic r);
    an_n = an; seg_n = seg; ready_i = r;
    @(posedge clk);
    if (!rst) model_edge({an, seg}, r);
    @(negedge clk);
    check("valid", 16'(valid_o), 16'(m_valid));
    check("value", value_o, m_val);
    check("invalid", 16'(invalid_o), 16'(m_inv));
    check("overrun", 16'(overrun_o), 16'(m_ovr));
    if (valid_o) begin nvalid++; last_val = value_o; last_inv = invalid_o; end
  endtask
  task automatic show(input int k, input logic [6:0] seg, input int n, input logic r);
    repeat (n) step(4'(~(4'b1 << k)), seg, r);
  endtask
  task automatic frame(input logic [15:0] v, input logic r);
    for (int k = 0; k < 4; k++) show(k, seg_tab[v[4*k +: 4]], 8, r);
  endtask
  task automatic idle(input int n, input logic r);
    repeat (n) step(4'hF, 7'h7F, r);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_value"}, value_o, 16'h0);
    check({tag, "_invalid"}, 16'(invalid_o), 16'h0);
    check({tag, "_valid"}, 16'(valid_o), 16'h0);
    check({tag, "_overrun"}, 16'(overrun_o), 16'h0);
  endtask
  initial begin
    model_reset();
    @(negedge clk);
    check_zero("rst_init");
    rst = 1'b0;
    idle(3, 1'b1);
    // basic scan with latency and single-cycle pulse
    nvalid = 0;
    for (int k = 0; k < 3; k++) show(k, seg_tab[k+1], 8, 1'b1);
    show(3, seg_tab[4], 5, 1'b1);
    check("lat_early", 16'(valid_o), 16'h0);
    show(3, seg_tab[4], 1, 1'b1);
    check("lat_rise", 16'(valid_o), 16'h1);
    check("scan_value", value_o, 16'h4321);
    check("scan_invalid", 16'(invalid_o), 16'h0);
    show(3, seg_tab[4], 2, 1'b1);
    check("pulse_count", 16'(nvalid), 16'd1);
    idle(3, 1'b1);
    // glitch rejection
    nvalid = 0;
    show(0, seg_tab[1], 8, 1'b1);
    show(1, seg_tab[2], 8, 1'b1);
    show(2, seg_tab[3], 2, 1'b1);
    show(2, 7'b0000000, 3, 1'b1);
    show(2, seg_tab[3], 8, 1'b1);
    show(3, seg_tab[4], 8, 1'b1);
    idle(3, 1'b1);
    check("glitch_count", 16'(nvalid), 16'd1);
    check("glitch_value", last_val, 16'h4321);
    // invalid pattern
    nvalid = 0;
    show(0, seg_tab[1], 8, 1'b1);
    show(1, 7'b1111111, 8, 1'b1);
    show(2, seg_tab[3], 8, 1'b1);
    show(3, seg_tab[4], 8, 1'b1);
    idle(3, 1'b1);
    check("inv_value", last_val, 16'h4301);
    check("inv_flags", 16'(last_inv), 16'b0010);
    // backpressure and overrun
    frame(16'h4321, 1'b0);
    idle(3, 1'b0);
    check("bp_valid1", 16'(valid_o), 16'h1);
    check("bp_value1", value_o, 16'h4321);
    check("bp_ovr0", 16'(overrun_o), 16'h0);
    frame(16'hBEEF, 1'b0);
    idle(3, 1'b0);
    check("bp_valid2", 16'(valid_o), 16'h1);
    check("bp_value2", value_o, 16'h4321);
    check("bp_ovr1", 16'(overrun_o), 16'h1);
    idle(1, 1'b1);
    check("bp_drop", 16'(valid_o), 16'h0);
    // ambiguous anodes
    nvalid = 0;
    repeat (10) step(4'b1100, seg_tab[1], 1'b1);
    idle(4, 1'b1);
    check("ambig_none", 16'(nvalid), 16'd0);
    // asynchronous reset mid-frame
    show(0, seg_tab[7], 8, 1'b1);
    show(1, seg_tab[8], 8, 1'b1);
    #2 rst = 1'b1;
    model_reset();
    #1 check_zero("rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("rst_hold");
    rst = 1'b0;
    nvalid = 0;
    show(2, seg_tab[5], 8, 1'b1);
    show(3, seg_tab[10], 8, 1'b1);
    idle(4, 1'b1);
    check("no_residue", 16'(nvalid), 16'd0);
    show(0, seg_tab[0], 8, 1'b1);
    show(1, seg_tab[12], 8, 1'b1);
    idle(3, 1'b1);
    check("post_rst_count", 16'(nvalid), 16'd1);
    check("post_rst_value", last_val, 16'hA5C0);
    // random scanning against the model
    for (int t = 0; t < 120; t++) begin
      logic [3:0] an;
      logic [6:0] sg;
      logic r;
      int dw;
      an = ($urandom % 10 == 0) ? 4'($urandom) : 4'(~(4'b1 << ($urandom % 4)));
      sg = ($urandom % 8 == 0) ? 7'($urandom) : seg_tab[$urandom % 16];
      r = 1'($urandom);
      dw = 1 + $urandom % 8;
      repeat (dw) step(an, sg, r);
    end
    idle(4, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
